// File: rtl/rv32i_decode_queue.sv
// RV32I decode stage: combinational decode of the fetch input, buffered in a
// DEPTH-entry FIFO and presented to execute from the queue head.
module rv32i_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_inst_i,
  input  logic [PC_W-1:0]          in_pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PC_W-1:0]          out_pc_o,
  output logic [4:0]               rd_o,
  output logic [4:0]               rs1_o,
  output logic [4:0]               rs2_o,
  output logic [2:0]               func3_o,
  output logic [31:0]              imm_o,
  output logic [3:0]               alu_op_o,
  output logic [1:0]               op_a_sel_o,
  output logic                     alu_src_o,
  output logic [1:0]               wb_sel_o,
  output logic                     reg_write_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic                     branch_o,
  output logic                     jump_o,
  output logic                     illegal_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic [31:0]     imm;
    logic [3:0]      alu_op;
    logic [1:0]      op_a_sel;
    logic            alu_src;
    logic [1:0]      wb_sel;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  bundle_t dec, head;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = in_inst_i[6:0];
  assign f3  = in_inst_i[14:12];
  assign f7  = in_inst_i[31:25];
  assign imm_i = {{20{in_inst_i[31]}}, in_inst_i[31:20]};
  assign imm_s = {{20{in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
  assign imm_b = {{19{in_inst_i[31]}}, in_inst_i[31], in_inst_i[7],
                  in_inst_i[30:25], in_inst_i[11:8], 1'b0};
  assign imm_u = {in_inst_i[31:12], 12'b0};
  assign imm_j = {{11{in_inst_i[31]}}, in_inst_i[31], in_inst_i[19:12],
                  in_inst_i[20], in_inst_i[30:21], 1'b0};

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc_i;
    dec.rd    = in_inst_i[11:7];
    dec.rs1   = in_inst_i[19:15];
    dec.rs2   = in_inst_i[24:20];
    dec.func3 = f3;
    unique case (opc)
      OPC_LUI: begin
        dec.imm = imm_u; dec.op_a_sel = 2'd2; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.op_a_sel = 2'd1; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.op_a_sel = 2'd1; dec.alu_src = 1'b1;
        dec.wb_sel = 2'd2; dec.jump = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i; dec.alu_src = 1'b1; dec.wb_sel = 2'd2;
        dec.jump = 1'b1; dec.reg_write = 1'b1;
        dec.illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.branch = 1'b1;
        // Condition is resolved from func3; the ALU only needs SUB or a compare.
        unique case (f3[2:1])
          2'b00:   dec.alu_op = 4'b1000;
          2'b10:   dec.alu_op = 4'b0010;
          2'b11:   dec.alu_op = 4'b0011;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.alu_src = 1'b1; dec.wb_sel = 2'd1;
        dec.mem_read = 1'b1; dec.reg_write = 1'b1;
        dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
        dec.illegal = (f3 == 3'b011) || f3[2];
      end
      OPC_OPIMM: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        dec.alu_op = {(f3 == 3'b101) & in_inst_i[30], f3};
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.imm = {27'b0, in_inst_i[24:20]};
          if (f3 == 3'b001) dec.illegal = (f7 != 7'b0000000);
          else              dec.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        end else begin
          dec.imm = imm_i;
        end
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op = {in_inst_i[30], f3};
        if (f7 == 7'b0100000) dec.illegal = (f3 != 3'b000) && (f3 != 3'b101);
        else                  dec.illegal = (f7 != 7'b0000000);
      end
      OPC_FENCE: ;
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  // Queue
  bundle_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign in_ready_o  = (count_q != CW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every output is gated by out_valid_o.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head = out_valid_o ? mem_q[rd_ptr_q] : '0;

  assign count_o     = count_q;
  assign out_pc_o    = head.pc;
  assign rd_o        = head.rd;
  assign rs1_o       = head.rs1;
  assign rs2_o       = head.rs2;
  assign func3_o     = head.func3;
  assign imm_o       = head.imm;
  assign alu_op_o    = head.alu_op;
  assign op_a_sel_o  = head.op_a_sel;
  assign alu_src_o   = head.alu_src;
  assign wb_sel_o    = head.wb_sel;
  assign reg_write_o = head.reg_write;
  assign mem_read_o  = head.mem_read;
  assign mem_write_o = head.mem_write;
  assign branch_o    = head.branch;
  assign jump_o      = head.jump;
  assign illegal_o   = head.illegal;
endmodule
